// File: rtl/seven_segment_scan_driver.sv
// Multiplexed seven-segment scanner with frame-synchronous double buffering.
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_segment_scan_driver #(
  parameter int DIGITS         = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 1000,
  parameter int HEX_MODE       = 0,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     digit_valid,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  output logic                  update_pending,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_start
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
  localparam logic [IW-1:0] I_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7f : 7'h00;
  localparam logic DP_OFF = (SEG_ACTIVE_LOW != 0);
  localparam logic [DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
  logic [4*DIGITS-1:0]   disp_val_q, disp_val_d;
  logic [DIGITS-1:0]     pend_vld_q, pend_vld_d;
  logic [DIGITS-1:0]     disp_vld_q, disp_vld_d;
  logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]     disp_dp_q, disp_dp_d;
  logic                  upd_q, upd_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic                  fs_q, fs_d;
  logic [DIGITS-1:0]     lz_blank;
  logic [3:0]            code;
  logic                  vld;
  logic                  wrap;
  logic                  commit;
  logic                  drive;

  function automatic logic [6:0] decode(input logic [3:0] c);
    logic [6:0] s;
    case (c)
      4'h0: s = 7'b0111111;
      4'h1: s = 7'b0000110;
      4'h2: s = 7'b1011011;
      4'h3: s = 7'b1001111;
      4'h4: s = 7'b1100110;
      4'h5: s = 7'b1101101;
      4'h6: s = 7'b1111101;
      4'h7: s = 7'b0000111;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1101111;
      4'ha: s = 7'b1110111;
      4'hb: s = 7'b1111100;
      4'hc: s = 7'b0111001;
      4'hd: s = 7'b1011110;
      4'he: s = 7'b1111001;
      default: s = 7'b1110001;
    endcase
    if (HEX_MODE == 0 && c > 4'd9) s = 7'b0000000;
    return s;
  endfunction

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // Walk from the most significant digit; stop at the first valid nonzero.
  always_comb begin
    logic above_zero;
    above_zero = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (i != 0 && above_zero && disp_vld_q[i] &&
          disp_val_q[4*i +: 4] == 4'd0)
        lz_blank[i] = 1'b1;
      if (disp_vld_q[i] && disp_val_q[4*i +: 4] != 4'd0)
        above_zero = 1'b0;
    end
  end
`else
  assign lz_blank = '0;
`endif

  always_comb begin
    wrap   = (presc_q == P_LAST) && (idx_q == I_LAST);
    commit = !enable || wrap;

    presc_d = '0;
    idx_d   = '0;
    if (enable) begin
      if (presc_q == P_LAST) begin
        idx_d = (idx_q == I_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
      end
    end

    pend_val_d = load ? value : pend_val_q;
    pend_vld_d = load ? digit_valid : pend_vld_q;
    pend_dp_d  = load ? dp_mask : pend_dp_q;
    disp_val_d = commit ? pend_val_q : disp_val_q;
    disp_vld_d = commit ? pend_vld_q : disp_vld_q;
    disp_dp_d  = commit ? pend_dp_q : disp_dp_q;
    upd_d      = load ? 1'b1 : (commit ? 1'b0 : upd_q);

    code  = disp_val_q[{idx_q, 2'b00} +: 4];
    vld   = disp_vld_q[idx_q];
    drive = enable && (presc_q >= P_BLANK);
    seg_d = SEG_OFF;
    dp_d  = DP_OFF;
    an_d  = AN_OFF;
    if (drive) begin
      an_d = AN_OFF ^ (DIGITS'(1) << idx_q);
      if (vld) begin
        seg_d = SEG_OFF ^ (lz_blank[idx_q] ? 7'd0 : decode(code));
        dp_d  = DP_OFF ^ disp_dp_q[idx_q];
      end
    end
    fs_d = enable && wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      idx_q      <= '0;
      pend_val_q <= '0;
      pend_vld_q <= '0;
      pend_dp_q  <= '0;
      disp_val_q <= '0;
      disp_vld_q <= '0;
      disp_dp_q  <= '0;
      upd_q      <= 1'b0;
      seg_q      <= SEG_OFF;
      dp_q       <= DP_OFF;
      an_q       <= AN_OFF;
      fs_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_val_q <= pend_val_d;
      pend_vld_q <= pend_vld_d;
      pend_dp_q  <= pend_dp_d;
      disp_val_q <= disp_val_d;
      disp_vld_q <= disp_vld_d;
      disp_dp_q  <= disp_dp_d;
      upd_q      <= upd_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      an_q       <= an_d;
      fs_q       <= fs_d;
    end
  end

  assign update_pending = upd_q;
  assign seg            = seg_q;
  assign dp             = dp_q;
  assign anode          = an_q;
  assign frame_start    = fs_q;

endmodule
